mdu_iterative: RTL and testbench



---
 rtl/mdu_iterative.sv | 160 ++++++++++++++++
 tb/tb_mdu_iterative.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MDU_FAST_MUL_EN to compute the four multiply ops in one cycle with a 33x33 signed multiplier.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, SPEC, DONE} state_t;

  state_t      state, state_n;
  logic [2:0]  op;
  logic        neg;
  logic [31:0] dsr;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [4:0]  cnt;

  logic        accept, is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic        div_zero, div_ovf, spec_case, neg_flag;
  logic [31:0] a_mag, b_mag, spec_val;
  logic        fast_go;
  logic [31:0] fast_res;

  assign accept   = start && !kill && (state == IDLE || state == DONE);
  assign is_div   = funct3[2];
  assign a_sgn    = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign b_sgn    = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign a_neg    = a_sgn && a[31];
  assign b_neg    = b_sgn && b[31];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = is_div && (b == 32'd0);
  assign div_ovf  = is_div && !funct3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign spec_case = div_zero || div_ovf;

  // Special divide results are parked in lo and copied to result in SPEC.
  always_comb begin
    spec_val = 32'd0;
    if (div_zero)
      spec_val = funct3[1] ? a : 32'hFFFF_FFFF;
    else
      spec_val = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  always_comb begin
    neg_flag = 1'b0;
    case (funct3)
      3'd1, 3'd4: neg_flag = a_neg ^ b_neg;
      3'd2, 3'd6: neg_flag = a_neg;
      default:    neg_flag = 1'b0;
    endcase
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [32:0] fa, fb;
  logic signed [63:0] fprod;
  assign fa       = {a_sgn & a[31], a};
  assign fb       = {b_sgn & b[31], b};
  assign fprod    = 64'(fa) * 64'(fb);
  assign fast_go  = accept && !funct3[2];
  assign fast_res = (funct3[1:0] == 2'd0) ? fprod[31:0] : fprod[63:32];
`else
  assign fast_go  = 1'b0;
  assign fast_res = 32'd0;
`endif

  // One iteration: multiply shifts the 64-bit {hi,lo} accumulator right,
  // divide shifts {hi,lo} left and records a quotient bit in lo.
  logic [32:0] mul_sum, div_sh, div_diff;
  logic [31:0] hi_n, lo_n;
  logic [63:0] prod, prod_s;
  logic [31:0] div_val, calc_res;

  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dsr} : 33'd0);
  assign div_sh   = {hi, lo[31]};
  assign div_diff = div_sh - {1'b0, dsr};

  always_comb begin
    hi_n = {mul_sum[31:0]};
    lo_n = lo;
    if (op[2]) begin
      if (!div_diff[32]) begin
        hi_n = div_diff[31:0];
        lo_n = {lo[30:0], 1'b1};
      end else begin
        hi_n = div_sh[31:0];
        lo_n = {lo[30:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[32:1];
      lo_n = {mul_sum[0], lo[31:1]};
    end
  end

  assign prod     = {hi_n, lo_n};
  assign prod_s   = neg ? -prod : prod;
  assign div_val  = op[1] ? hi_n : lo_n;
  assign calc_res = op[2] ? (neg ? -div_val : div_val)
                          : ((op[1:0] == 2'd0) ? prod_s[31:0] : prod_s[63:32]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (accept)      state_n = fast_go ? DONE : (spec_case ? SPEC : CALC);
        else             state_n = IDLE;
      end
      CALC:    if (cnt == 5'd31) state_n = DONE;
      SPEC:    state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (kill) state_n = IDLE;
  end

  assign busy = (state == CALC) || (state == SPEC);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op     <= 3'd0;
      neg    <= 1'b0;
      dsr    <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      cnt    <= 5'd0;
      result <= 32'd0;
    end else if (accept) begin
      op  <= funct3;
      neg <= neg_flag;
      dsr <= b_mag;
      hi  <= 32'd0;
      lo  <= spec_case ? spec_val : a_mag;
      cnt <= 5'd0;
      if (fast_go) result <= fast_res;
    end else if (state == CALC) begin
      cnt <= cnt + 5'd1;
      hi  <= hi_n;
      lo  <= lo_n;
      if (cnt == 5'd31 && !kill) result <= calc_res;
    end else if (state == SPEC && !kill) begin
      result <= lo;
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: arithmetic reference model plus per-cycle done/busy/result checks.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  mdu_iterative #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          pending = 1'b0;
  int          issue_cyc = 0;
  int          done_cyc = 0;
  logic [31:0] exp_val = 32'd0;
  logic [31:0] exp_res = 32'd0;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    int          xi, yi;
    xi = x; yi = y;
    sx = xi; sy = yi;
    ux = {32'd0, x}; uy = {32'd0, y};
    case (f)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return xi / yi;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return xi % yi;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2])
      return (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 2 : 33;
`ifdef MDU_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  // Compare process: one sample per cycle, 1 time unit after the rising edge.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (pending && cyc == done_cyc) begin
      chk("done", 32'(done), 32'd1);
      chk("result", result, exp_val);
      exp_res = exp_val;
      pending = 1'b0;
    end else begin
      chk("done_low", 32'(done), 32'd0);
      chk("result_hold", result, exp_res);
    end
    chk("busy", 32'(busy), 32'(pending && cyc > issue_cyc && cyc < done_cyc));
  end

  // Called at a falling edge; start is held for exactly one rising edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    funct3 = f; a = x; b = y; start = 1'b1;
    pending   = 1'b1;
    issue_cyc = cyc;
    done_cyc  = cyc + lat(f, x, y);
    exp_val   = model(f, x, y);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (pending && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (pending) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout waiting for done: pending %0d, required 0", pending);
      pending = 1'b0;
    end
  endtask

  task automatic run_lit(input string name, input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] lit);
    issue(f, x, y);
    wait_done();
    chk(name, result, lit);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset during CALC at cycle 10
    issue(3'd0, 32'd100, 32'd200);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    pending = 1'b0;
    exp_res = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_lit("mul_3x4", 3'd0, 32'd3, 32'd4, 32'h0000_000C);

    // Back-to-back multiplies
    run_lit("mul_m1x5",    3'd0, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB);
    run_lit("mulh_m1x5",   3'd1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF);
    run_lit("mulhu_m1x5",  3'd3, 32'hFFFF_FFFF, 32'd5, 32'h0000_0004);
    run_lit("mulhsu_m1x5", 3'd2, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF);
    run_lit("mulhsu_min",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_lit("mul_shift",   3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780);

    // Divides
    run_lit("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_lit("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_lit("div_100_m7", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
    run_lit("rem_100_m7", 3'd6, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002);
    run_lit("remu_big",  3'd7, 32'hFFFF_FFFF, 32'd10, 32'h0000_0005);
    run_lit("divu_big",  3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);

    // Kill at CALC cycle 5: result must keep 0x7FFFFFFC
    issue(3'd0, 32'd9, 32'd9);
    repeat (4) @(negedge clk);
    kill = 1'b1;
    pending = 1'b0;
    @(negedge clk);
    kill = 1'b0;
    repeat (3) @(negedge clk);
    chk("kill_hold", result, 32'h7FFF_FFFC);

    // kill beats start in the same cycle
    kill = 1'b1; start = 1'b1; funct3 = 3'd0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    kill = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    // Special divide cases
    run_lit("divu_by0", 3'd5, 32'd10, 32'd0, 32'hFFFF_FFFF);
    run_lit("rem_by0",  3'd6, 32'd10, 32'd0, 32'h0000_000A);
    run_lit("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_lit("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    @(negedge clk);

    // start and operand changes while busy are ignored
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    repeat (3) @(negedge clk);
    start = 1'b1; funct3 = 3'd4; a = 32'd1; b = 32'd0;
    @(negedge clk);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    wait_done();
    chk("busy_start_ignored", result, 32'h4000_0000);

    run_lit("mul_7x6", 3'd0, 32'd7, 32'd6, 32'h0000_002A);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
